ad5681_req_arbiter: RTL and testbench



---
 rtl/ad5681_req_arbiter_if.sv | 38 +++
 rtl/ad5681_req_arbiter.sv | 153 +++++++++++++++
 tb/tb_ad5681_req_arbiter.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/ad5681_req_arbiter_if.sv
// ---------------------------------------------------------------------------
// ad5681_req_arbiter_if
// Bundles the requester handshake, the status outputs and the AD5681 driver
// hookup of ad5681_req_arbiter.
//   req/code/ack          : requester side (level req, one-cycle ack pulse)
//   busy/grant_idx        : arbiter status
//   err_timeout/err_clr   : sticky LDAC timeout flag and its clear
//   drv_data/drv_start    : 24-bit frame and start level to the driver
//   drv_ldac_n            : active-low LDAC from the driver (frame complete)
// Modports:
//   master : the surroundings (requesters, error handler, driver)
//   slave  : the arbiter itself
// ---------------------------------------------------------------------------
interface ad5681_req_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 12
);
    logic [NUM_REQ-1:0]         req;
    logic [NUM_REQ*DATA_W-1:0]  code;
    logic [NUM_REQ-1:0]         ack;
    logic                       busy;
    logic [$clog2(NUM_REQ)-1:0] grant_idx;
    logic                       err_timeout;
    logic                       err_clr;
    logic [23:0]                drv_data;
    logic                       drv_start;
    logic                       drv_ldac_n;

    modport master (
        output req, code, err_clr, drv_ldac_n,
        input  ack, busy, grant_idx, err_timeout, drv_data, drv_start
    );

    modport slave (
        input  req, code, err_clr, drv_ldac_n,
        output ack, busy, grant_idx, err_timeout, drv_data, drv_start
    );
endinterface

// File: rtl/ad5681_req_arbiter.sv
// ---------------------------------------------------------------------------
// ad5681_req_arbiter
// Round-robin arbiter/sequencer sharing one AD5681 serial driver between
// NUM_REQ requesters. A granted requester's code is packed into the frame
// {CMD, code, zeros}, the driver is started, completion is taken from the
// driver's LDAC low pulse, the requester is acked and a minimum gap is kept
// before the next frame. A missing LDAC pulse ends the frame after TIMEOUT
// cycles and sets a sticky error flag.
// Ports:
//   clk : system clock (shared with the driver)
//   rst : asynchronous, active-high reset
//   bus : ad5681_req_arbiter_if.slave (requests, status, driver signals)
// ---------------------------------------------------------------------------
module ad5681_req_arbiter #(
    parameter int         NUM_REQ    = 4,
    parameter int         DATA_W     = 12,
    parameter logic [3:0] CMD        = 4'b0011,
    parameter int         TIMEOUT    = 64,
    parameter int         GAP_CYCLES = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    ad5681_req_arbiter_if.slave  bus
);
    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int TMR_W = $clog2(TIMEOUT + 1);
    localparam int GAP_W = $clog2(GAP_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, WAIT_LDAC, GAP} state_t;

    state_t             state, state_nxt;
    logic [TMR_W-1:0]   timer, timer_nxt;
    logic [GAP_W-1:0]   gap_cnt, gap_nxt;
    logic [NUM_REQ-1:0] ack_nxt;
    logic [IDX_W-1:0]   grant_nxt;
    logic [23:0]        data_nxt;
    logic               start_nxt;
    logic               err_nxt;

    logic               rr_found;
    logic [IDX_W-1:0]   rr_sel;
    logic               timeout_hit;
    logic               gap_done;

    // Round-robin search: first pending request strictly after the last
    // grant, wrapping around, so the last winner has the lowest priority.
    always_comb begin
        int idx;
        idx      = 0;
        rr_found = 1'b0;
        rr_sel   = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = int'(bus.grant_idx) + k;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (!rr_found && bus.req[IDX_W'(idx)]) begin
                rr_found = 1'b1;
                rr_sel   = IDX_W'(idx);
            end
        end
    end

    // LDAC low takes precedence, so a timeout only counts while LDAC is high.
    assign timeout_hit = (state == WAIT_LDAC) && bus.drv_ldac_n &&
                         (timer == TMR_W'(TIMEOUT - 1));
    // The gap also waits for the driver to release LDAC.
    assign gap_done    = (gap_cnt >= GAP_W'(GAP_CYCLES - 1)) && bus.drv_ldac_n;

    // State register
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of process ordering.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic
    // NOTE: every combinational output gets a default first; a path that
    // leaves a variable unassigned would infer a latch.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:      if (rr_found) state_nxt = WAIT_LDAC;
            WAIT_LDAC: if (!bus.drv_ldac_n || timeout_hit) state_nxt = GAP;
            GAP:       if (gap_done) state_nxt = IDLE;
            default:   state_nxt = IDLE;
        endcase
    end

    // Output logic: busy directly, plus next values of the registered outputs
    always_comb begin
        bus.busy  = (state != IDLE);
        ack_nxt   = '0;
        grant_nxt = bus.grant_idx;
        data_nxt  = bus.drv_data;
        start_nxt = bus.drv_start;
        timer_nxt = timer;
        gap_nxt   = gap_cnt;
        case (state)
            IDLE: begin
                gap_nxt = '0;
                if (rr_found) begin
                    grant_nxt = rr_sel;
                    // Frame is captured once here and held until the next
                    // grant; the driver reloads its shifter while start is high.
                    data_nxt  = {CMD, bus.code[rr_sel*DATA_W +: DATA_W],
                                 {(20-DATA_W){1'b0}}};
                    start_nxt = 1'b1;
                    timer_nxt = '0;
                end
            end
            WAIT_LDAC: begin
                timer_nxt = timer + 1'b1;
                gap_nxt   = '0;
                if (!bus.drv_ldac_n) begin
                    start_nxt              = 1'b0;
                    ack_nxt[bus.grant_idx] = 1'b1;
                end else if (timeout_hit) begin
                    start_nxt = 1'b0;
                end
            end
            GAP: begin
                // Saturate: LDAC may be held low for an unbounded time.
                if (gap_cnt < GAP_W'(GAP_CYCLES - 1)) gap_nxt = gap_cnt + 1'b1;
            end
            default: ;
        endcase
        // A timeout on the same cycle as err_clr keeps the flag set.
        if (timeout_hit)      err_nxt = 1'b1;
        else if (bus.err_clr) err_nxt = 1'b0;
        else                  err_nxt = bus.err_timeout;
    end

    // Datapath / output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.ack         <= '0;
            bus.grant_idx   <= IDX_W'(NUM_REQ - 1);
            bus.drv_data    <= '0;
            bus.drv_start   <= 1'b0;
            bus.err_timeout <= 1'b0;
            timer           <= '0;
            gap_cnt         <= '0;
        end else begin
            bus.ack         <= ack_nxt;
            bus.grant_idx   <= grant_nxt;
            bus.drv_data    <= data_nxt;
            bus.drv_start   <= start_nxt;
            bus.err_timeout <= err_nxt;
            timer           <= timer_nxt;
            gap_cnt         <= gap_nxt;
        end
    end
endmodule

// File: tb/tb_ad5681_req_arbiter.sv
// ---------------------------------------------------------------------------
// tb_ad5681_req_arbiter
// Directed bench for ad5681_req_arbiter (NUM_REQ=4, DATA_W=12, TIMEOUT=64,
// GAP_CYCLES=4). Inputs change and outputs are sampled on the falling edge;
// the driver's LDAC output is played by hand in each step.
// ---------------------------------------------------------------------------
module tb_ad5681_req_arbiter;
    logic clk = 1'b0;
    logic rst;
    int   checks   = 0;
    int   failures = 0;

    ad5681_req_arbiter_if #(.NUM_REQ(4), .DATA_W(12)) bus ();

    ad5681_req_arbiter #(
        .NUM_REQ(4), .DATA_W(12), .CMD(4'b0011), .TIMEOUT(64), .GAP_CYCLES(4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Advance falling edges until drv_start is seen high (bounded).
    task automatic wait_start(input string tag);
        int n;
        n = 0;
        while (bus.drv_start !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check(tag, bus.drv_start, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0]  exp_grant [5];
        logic [23:0] exp_frame [5];
        int          first;
        logic        busy_hold;

        exp_grant = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        exp_frame = '{24'h300100, 24'h300200, 24'h300300, 24'h300400, 24'h300100};

        rst            = 1'b1;
        bus.req        = '0;
        bus.code       = {12'h004, 12'h003, 12'h002, 12'h001};
        bus.err_clr    = 1'b0;
        bus.drv_ldac_n = 1'b1;
        repeat (2) @(negedge clk);

        // Reset state
        check("rst_start", bus.drv_start, 0);
        check("rst_ack",   bus.ack, 0);
        check("rst_busy",  bus.busy, 0);
        check("rst_grant", bus.grant_idx, 3);
        check("rst_err",   bus.err_timeout, 0);
        check("rst_data",  bus.drv_data, 0);
        rst = 1'b0;

        // Single request, code 0xABC
        bus.code[11:0] = 12'hABC;
        bus.req        = 4'b0001;
        @(negedge clk);
        check("t1_start", bus.drv_start, 1);
        check("t1_data",  bus.drv_data, 24'h3ABC00);
        check("t1_grant", bus.grant_idx, 0);
        check("t1_busy",  bus.busy, 1);
        repeat (28) @(negedge clk);
        check("t1_hold_start", bus.drv_start, 1);
        check("t1_hold_ack",   bus.ack, 0);
        bus.drv_ldac_n = 1'b0;
        @(negedge clk);
        check("t1_ack",  bus.ack, 4'b0001);
        check("t1_stop", bus.drv_start, 0);
        bus.drv_ldac_n = 1'b1;
        bus.req        = 4'b0000;
        @(negedge clk);
        check("t1_ack_once", bus.ack, 0);
        repeat (2) @(negedge clk);
        check("t1_gap_busy", bus.busy, 1);
        @(negedge clk);
        check("t1_idle_busy", bus.busy, 0);
        check("t1_idle_data", bus.drv_data, 24'h3ABC00);

        // Round robin from a fresh reset, all requesting
        rst = 1'b1;
        @(negedge clk);
        rst            = 1'b0;
        bus.code[11:0] = 12'h001;
        bus.req        = 4'b1111;
        for (int f = 0; f < 5; f++) begin
            wait_start("t2_start");
            check("t2_grant", bus.grant_idx, exp_grant[f]);
            check("t2_data",  bus.drv_data, exp_frame[f]);
            repeat (3) @(negedge clk);
            bus.drv_ldac_n = 1'b0;
            @(negedge clk);
            check("t2_ack",      bus.ack, 4'b0001 << exp_grant[f]);
            check("t2_data_gap", bus.drv_data, exp_frame[f]);
            bus.drv_ldac_n = 1'b1;
            if (f == 4) bus.req = 4'b0000;
        end
        repeat (6) @(negedge clk);
        check("t2_idle", bus.busy, 0);

        // Timeout with LDAC stuck high, then retry and clear
        bus.req = 4'b0100;
        wait_start("t3_start");
        check("t3_grant", bus.grant_idx, 2);
        repeat (63) @(negedge clk);
        check("t3_start_hi", bus.drv_start, 1);
        @(negedge clk);
        check("t3_start_lo", bus.drv_start, 0);
        check("t3_err",      bus.err_timeout, 1);
        check("t3_noack",    bus.ack, 0);
        wait_start("t3_retry");
        check("t3_retry_grant", bus.grant_idx, 2);
        check("t3_err_held",    bus.err_timeout, 1);
        bus.err_clr = 1'b1;
        @(negedge clk);
        bus.err_clr = 1'b0;
        check("t3_clr", bus.err_timeout, 0);
        bus.drv_ldac_n = 1'b0;
        @(negedge clk);
        check("t3_retry_ack", bus.ack, 4'b0100);
        bus.drv_ldac_n = 1'b1;
        bus.req        = 4'b0000;
        repeat (6) @(negedge clk);

        // LDAC low on the same cycle as timer==63: ack wins
        bus.req = 4'b0001;
        wait_start("t4a_start");
        check("t4a_grant", bus.grant_idx, 0);
        repeat (63) @(negedge clk);
        bus.drv_ldac_n = 1'b0;
        @(negedge clk);
        check("t4a_ack",   bus.ack, 4'b0001);
        check("t4a_err",   bus.err_timeout, 0);
        check("t4a_start", bus.drv_start, 0);
        bus.drv_ldac_n = 1'b1;
        bus.req        = 4'b0000;
        repeat (6) @(negedge clk);

        // err_clr coincident with a timeout: flag stays set
        bus.req = 4'b0010;
        wait_start("t4b_start");
        check("t4b_grant", bus.grant_idx, 1);
        repeat (63) @(negedge clk);
        bus.err_clr = 1'b1;
        @(negedge clk);
        bus.err_clr = 1'b0;
        check("t4b_err",   bus.err_timeout, 1);
        check("t4b_noack", bus.ack, 0);
        check("t4b_start", bus.drv_start, 0);
        bus.req = 4'b0000;
        repeat (6) @(negedge clk);
        bus.err_clr = 1'b1;
        @(negedge clk);
        bus.err_clr = 1'b0;
        check("t4b_clr", bus.err_timeout, 0);

        // LDAC held low 10 cycles past the ack with another request pending
        bus.req = 4'b0001;
        wait_start("t5_start");
        check("t5_grant", bus.grant_idx, 0);
        repeat (3) @(negedge clk);
        bus.drv_ldac_n = 1'b0;
        @(negedge clk);
        check("t5_ack", bus.ack, 4'b0001);
        bus.req   = 4'b0010;
        first     = 0;
        busy_hold = 1'b0;
        for (int k = 1; k <= 30; k++) begin
            @(negedge clk);
            if (bus.drv_start === 1'b1 && first == 0) first = k;
            if (k == 9)  busy_hold = bus.busy;
            if (k == 10) bus.drv_ldac_n = 1'b1;
        end
        check("t5_first_start", first, 12);
        check("t5_hold_busy",   busy_hold, 1);
        check("t5_next_grant",  bus.grant_idx, 1);
        check("t5_next_data",   bus.drv_data, 24'h300200);

        // Let this frame time out (req held) so the flag is set, then reset
        // during the retry's WAIT_LDAC.
        repeat (50) @(negedge clk);
        check("t6_err_pre", bus.err_timeout, 1);
        wait_start("t6_retry");
        repeat (2) @(negedge clk);
        check("t6_start_pre", bus.drv_start, 1);
        #2 rst = 1'b1;
        #1;
        check("t6_rst_start", bus.drv_start, 0);
        check("t6_rst_ack",   bus.ack, 0);
        check("t6_rst_busy",  bus.busy, 0);
        check("t6_rst_err",   bus.err_timeout, 0);
        check("t6_rst_data",  bus.drv_data, 0);
        check("t6_rst_grant", bus.grant_idx, 3);
        @(negedge clk);
        rst = 1'b0;
        wait_start("t6_start");
        check("t6_grant", bus.grant_idx, 1);
        check("t6_data",  bus.drv_data, 24'h300200);
        bus.drv_ldac_n = 1'b0;
        @(negedge clk);
        check("t6_ack", bus.ack, 4'b0010);
        bus.drv_ldac_n = 1'b1;
        bus.req        = 4'b0000;
        repeat (6) @(negedge clk);
        check("t6_idle", bus.busy, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
